counter_ctrl_unit: RTL and testbench
====================================

Name: counter_ctrl_unit

Overview:
- Control FSM and tick scheduler for the 14-bit 0..MAX_COUNT up/down counter (ports clk, rst, i_tick, mode, o_count).
- Takes single-cycle button pulses (run/stop, clear, mode) and drives the counter's tick, clear and mode inputs.
- Sits between the button debounce/edge-detect stage and the counter datapath.
- The counter only advances while the FSM is in RUN, at a prescaled rate.

Parameters:
- TICK_DIV, 10_000_000, system-clock cycles per counter tick (100 MHz -> 10 Hz); must be >= 2.
- MAX_COUNT, 9999, counter terminal value for up mode.
- CNT_W, 14, width of i_count.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_btn_run  input  1  one-cycle pulse, toggles run/stop.
- i_btn_clear  input  1  one-cycle pulse, clear request.
- i_btn_mode  input  1  one-cycle pulse, toggles count direction.
- i_count  input  CNT_W  current counter value (o_count of the counter).
- o_tick  output  1  one-cycle tick pulse to counter i_tick.
- o_clear  output  1  one-cycle synchronous clear to counter.
- o_mode  output  1  direction to counter: 0 = up, 1 = down.
- o_run  output  1  status: high while in RUN.

Behaviour:
- Reset (async, rst=1):
  - state=STOP; prescaler=0.
  - o_tick=0, o_clear=0, o_mode=0, o_run=0.
- States (2-bit encoding): STOP=0, RUN=1, CLEAR=2. Encoding 3 is illegal and goes to STOP on the next cycle.
- STOP:
  - i_btn_clear -> CLEAR.
  - Otherwise i_btn_run -> RUN.
  - Clear has priority when both pulses arrive in the same cycle.
- RUN:
  - i_btn_run -> STOP.
  - i_btn_clear and i_btn_mode are ignored.
- CLEAR:
  - Unconditionally -> STOP on the next cycle. All buttons are ignored.
- o_run = (state==RUN). o_clear = (state==CLEAR), high for exactly 1 cycle. Both are derived from the state register, so they are glitch-free.
- o_mode:
  - Toggles on i_btn_mode only while state==STOP. Ignored in RUN and CLEAR.
  - Takes effect the cycle after the pulse.
  - Holds its value across CLEAR and RUN.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and wraps to 0.
  - Forced to 0 in STOP and CLEAR, so a stop/run sequence restarts the period.
- o_tick:
  - Registered. Goes high for 1 cycle in the cycle after the prescaler equals TICK_DIV-1 while in RUN.
  - First tick is TICK_DIV cycles after the first RUN cycle; then one tick every TICK_DIV cycles.
- Stop in the same cycle the prescaler hits TICK_DIV-1: that tick is suppressed. o_tick is never asserted while o_run=0.
- Without AUTO_STOP_EN, counter wrap-around (MAX_COUNT->0 up, 0->MAX_COUNT down) is the counter's own behaviour. This block takes no action on it.
- Reset mid-RUN: all outputs drop to reset values immediately (async). No tick is emitted.

Optional Feature:
- Macro: AUTO_STOP_EN.
- When defined:
  - In RUN, when the prescaler hits TICK_DIV-1 and i_count is at the terminal value (MAX_COUNT with o_mode=0, or 0 with o_mode=1), the tick is suppressed.
  - The FSM goes to STOP instead, so the counter stops at its terminal value and never wraps.
  - i_btn_run in that same cycle does not override the auto-stop.
- When undefined: the i_count port still exists but is unused. Ticks are issued regardless of the counter value.

Test Plan:
- TICK_DIV=4. Reset, pulse i_btn_run -> o_run=1 next cycle; o_tick pulses 1 cycle wide, first after 4 cycles, then every 4 cycles. Pulse i_btn_run again -> o_run=0 and no further ticks.
- In STOP, pulse i_btn_clear -> o_clear=1 for exactly 1 cycle, then state STOP. Same-cycle i_btn_run+i_btn_clear in STOP -> CLEAR, then STOP, o_run stays 0.
- i_btn_mode in STOP -> o_mode 0->1. i_btn_mode during RUN -> o_mode unchanged. A subsequent CLEAR keeps o_mode=1.
- Stop pulse coincident with prescaler=3 -> no o_tick emitted. Re-run -> first tick 4 cycles later (prescaler restarted).
- rst asserted mid-RUN between clock edges -> o_run, o_tick and o_mode are 0 immediately. After release, state is STOP.
- AUTO_STOP_EN defined:
  - Up mode, i_count=9999 at the tick point -> no o_tick, o_run=0 next cycle.
  - Down mode, i_count=0 -> same result.
  - Without the macro, i_count=9999 -> o_tick is still issued.

Source files
------------

// File: rtl/counter_ctrl_unit.sv
// -----------------------------------------------------------------------------
// counter_ctrl_unit
//
// Control FSM and tick scheduler for a 0..MAX_COUNT up/down counter. It takes
// one-cycle button pulses from the debounce/edge-detect stage and drives the
// counter's tick, clear and mode inputs. The counter only advances while the
// FSM is in RUN, at a rate of one tick every TICK_DIV clock cycles.
//
// Optional feature (compile-time macro): AUTO_STOP_EN
//   When defined, the block stops at the counter's terminal value instead of
//   issuing the tick that would make the counter wrap. The terminal value is
//   MAX_COUNT in up mode and 0 in down mode. When the macro is undefined,
//   i_count is accepted but not used.
//
// Parameters:
//   TICK_DIV   clock cycles per counter tick (must be >= 2)
//   MAX_COUNT  counter terminal value in up mode
//   CNT_W      width of i_count
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   rst          in   asynchronous, active-high reset
//   i_btn_run    in   one-cycle pulse, toggles run/stop
//   i_btn_clear  in   one-cycle pulse, clear request (honoured in STOP only)
//   i_btn_mode   in   one-cycle pulse, toggles direction (honoured in STOP only)
//   i_count      in   current counter value
//   o_tick       out  one-cycle tick pulse to the counter
//   o_clear      out  one-cycle synchronous clear to the counter
//   o_mode       out  count direction: 0 = up, 1 = down
//   o_run        out  high while in RUN
// -----------------------------------------------------------------------------
module counter_ctrl_unit #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int MAX_COUNT = 9999,
  parameter int CNT_W     = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_btn_run,
  input  logic             i_btn_clear,
  input  logic             i_btn_mode,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_tick,
  output logic             o_clear,
  output logic             o_mode,
  output logic             o_run
);

  // Prescaler only needs to hold 0..TICK_DIV-1.
  localparam int               PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Encoding 2'd3 is unused; the default branch of the next-state logic
  // steers it back to STOP.
  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] pre_reg,   pre_next;
  logic             tick_reg,  tick_next;
  logic             mode_reg,  mode_next;

  logic period_end;
  logic auto_stop;

  // Last cycle of a tick period while running.
  assign period_end = (state_reg == RUN) && (pre_reg == PRE_LAST);

`ifdef AUTO_STOP_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

  logic at_terminal;

  // The counter's value is compared against the terminal value of the
  // direction currently selected; the tick that would wrap it is replaced
  // by a transition to STOP.
  assign at_terminal = mode_reg ? (i_count == '0) : (i_count == CNT_MAX);
  assign auto_stop   = period_end && at_terminal;
`else
  logic unused_inputs;

  // The counter value plays no role in this build.
  assign unused_inputs = (^i_count) ^ MAX_COUNT[0];
  assign auto_stop     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state, prescaler, tick and mode logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pre_next   = '0;        // prescaler rests at zero unless RUN continues
    tick_next  = 1'b0;
    mode_next  = mode_reg;

    case (state_reg)
      STOP: begin
        // Clear wins over run when both pulses arrive together.
        if (i_btn_clear) begin
          state_next = CLEAR;
        end else if (i_btn_run) begin
          state_next = RUN;
        end
        if (i_btn_mode) begin
          mode_next = ~mode_reg;
        end
      end

      RUN: begin
        // Clear and mode pulses are deliberately ignored while running.
        if (auto_stop) begin
          // Auto-stop takes precedence over a coincident run/stop pulse;
          // either way the result is STOP with no tick.
          state_next = STOP;
        end else if (i_btn_run) begin
          // Stopping on the period's last cycle swallows that tick, so a
          // tick is never seen after o_run has dropped.
          state_next = STOP;
        end else if (period_end) begin
          tick_next = 1'b1;
          pre_next  = '0;
        end else begin
          pre_next = pre_reg + 1'b1;
        end
      end

      CLEAR: begin
        // One-cycle state: the clear pulse lasts exactly one clock.
        state_next = STOP;
      end

      default: begin
        state_next = STOP;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= STOP;
      pre_reg   <= '0;
      tick_reg  <= 1'b0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pre_reg   <= pre_next;
      tick_reg  <= tick_next;
      mode_reg  <= mode_next;
    end
  end

  // All outputs come straight from registers or a decode of the state
  // register, so the counter sees glitch-free controls.
  assign o_tick  = tick_reg;
  assign o_clear = (state_reg == CLEAR);
  assign o_mode  = mode_reg;
  assign o_run   = (state_reg == RUN);

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl_unit
//
// Directed bench for counter_ctrl_unit with TICK_DIV=4. Every stimulus cycle
// pushes the hand-computed outputs expected after the next rising edge into a
// queue; a monitor pops one entry per cycle and compares. Expected vectors are
// packed as {o_tick, o_clear, o_mode, o_run}.
// Define AUTO_STOP_EN for both bench and RTL to exercise the auto-stop build.
// -----------------------------------------------------------------------------
module tb_counter_ctrl_unit;

  localparam int TICK_DIV  = 4;
  localparam int MAX_COUNT = 9999;
  localparam int CNT_W     = 14;
  localparam logic [CNT_W-1:0] MID = 14'd5000;

  logic             clk;
  logic             rst;
  logic             i_btn_run;
  logic             i_btn_clear;
  logic             i_btn_mode;
  logic [CNT_W-1:0] i_count;
  logic             o_tick;
  logic             o_clear;
  logic             o_mode;
  logic             o_run;

  typedef struct {
    logic [3:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  counter_ctrl_unit #(
    .TICK_DIV (TICK_DIV),
    .MAX_COUNT(MAX_COUNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn_run  (i_btn_run),
    .i_btn_clear(i_btn_clear),
    .i_btn_mode (i_btn_mode),
    .i_count    (i_count),
    .o_tick     (o_tick),
    .o_clear    (o_clear),
    .o_mode     (o_mode),
    .o_run      (o_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: tick/clear/mode/run got=%b expected=%b", name, act, exp);
    end else begin
      $display("ok   %s: tick/clear/mode/run=%b", name, act);
    end
  endtask

  // Monitor: the DUT presents a new output set after every rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, {o_tick, o_clear, o_mode, o_run}, e.v);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic br, input logic bc, input logic bm,
                      input logic [CNT_W-1:0] cnt, input logic [3:0] e,
                      input string nm);
    exp_t x;
    @(negedge clk);
    i_btn_run   = br;
    i_btn_clear = bc;
    i_btn_mode  = bm;
    i_count     = cnt;
    x.v    = e;
    x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  task automatic idle(input logic [3:0] e, input string nm);
    step(1'b0, 1'b0, 1'b0, MID, e, nm);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    i_btn_run   = 1'b0;
    i_btn_clear = 1'b0;
    i_btn_mode  = 1'b0;
    i_count     = MID;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {o_tick, o_clear, o_mode, o_run}, 4'b0000);
    rst = 1'b0;

    // --- run, periodic ticks, stop ---------------------------------------
    step(1, 0, 0, MID, 4'b0001, "run_start");
    for (int i = 0; i < 3; i++) idle(4'b0001, "run_pre");
    idle(4'b1001, "first_tick");
    for (int i = 0; i < 3; i++) idle(4'b0001, "run_pre2");
    idle(4'b1001, "second_tick");
    idle(4'b0001, "after_tick");
    step(1, 0, 0, MID, 4'b0000, "stop");
    idle(4'b0000, "stopped_a");
    idle(4'b0000, "stopped_b");

    // --- clear in STOP, clear priority over run ---------------------------
    step(0, 1, 0, MID, 4'b0100, "clear_pulse");
    idle(4'b0000, "clear_done");
    step(1, 1, 0, MID, 4'b0100, "clear_beats_run");
    idle(4'b0000, "clear_then_stop");
    idle(4'b0000, "still_stop");

    // --- mode handling ----------------------------------------------------
    step(0, 0, 1, MID, 4'b0010, "mode_toggle");
    step(1, 0, 0, MID, 4'b0011, "run_down");
    step(0, 0, 1, MID, 4'b0011, "mode_ignored_run");
    step(0, 1, 0, MID, 4'b0011, "clear_ignored_run");
    idle(4'b0011, "run_down_pre3");
    idle(4'b1011, "tick_down");
    step(1, 0, 0, MID, 4'b0010, "stop_down");
    step(0, 1, 0, MID, 4'b0110, "clear_keeps_mode");
    step(0, 0, 1, MID, 4'b0010, "mode_ignored_clear");
    idle(4'b0010, "stop_mode1");
    step(0, 0, 1, MID, 4'b0000, "mode_back_up");

    // --- stop on the period's last cycle, then restart --------------------
    step(0, 0, 1, MID, 4'b0010, "mode_down_again");
    step(1, 0, 0, MID, 4'b0011, "run_b");
    for (int i = 0; i < 3; i++) idle(4'b0011, "run_b_pre");
    step(1, 0, 0, MID, 4'b0010, "stop_at_pre3_no_tick");
    idle(4'b0010, "no_late_tick");
    step(1, 0, 0, MID, 4'b0011, "rerun");
    for (int i = 0; i < 3; i++) idle(4'b0011, "rerun_pre");
    idle(4'b1011, "rerun_tick_after_4");
    idle(4'b0011, "rerun_pre1");

    // --- asynchronous reset mid-RUN ---------------------------------------
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", {o_tick, o_clear, o_mode, o_run}, 4'b0000);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4'b0000, "post_reset_stop");
    step(1, 0, 0, MID, 4'b0001, "post_reset_run");
    step(1, 0, 0, MID, 4'b0000, "post_reset_stop2");

    // --- terminal value at the tick point ---------------------------------
    step(1, 0, 0, 14'd9999, 4'b0001, "run_at_max");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 14'd9999, 4'b0001, "at_max_pre");
`ifdef AUTO_STOP_EN
    step(0, 0, 0, 14'd9999, 4'b0000, "auto_stop_up");
    step(0, 0, 0, 14'd9999, 4'b0000, "auto_stop_up_hold");
`else
    step(0, 0, 0, 14'd9999, 4'b1001, "tick_at_max");
    step(1, 0, 0, 14'd9999, 4'b0000, "stop_at_max");
`endif
    step(0, 0, 1, 14'd0, 4'b0010, "mode_down_term");
    step(1, 0, 0, 14'd0, 4'b0011, "run_at_zero");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 14'd0, 4'b0011, "at_zero_pre");
`ifdef AUTO_STOP_EN
    step(0, 0, 0, 14'd0, 4'b0010, "auto_stop_down");
    step(0, 0, 0, 14'd0, 4'b0010, "auto_stop_down_hold");
`else
    step(0, 0, 0, 14'd0, 4'b1011, "tick_at_zero");
    step(1, 0, 0, 14'd0, 4'b0010, "stop_at_zero");
`endif

    // Let the monitor drain; anything left over means outputs went unchecked.
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
